// File: rtl/counter_run_scheduler.sv
// counter_run_scheduler
//
// Shares one embedded WIDTH-bit up-counter among NREQ requesters. A
// round-robin arbiter picks one pending requester, latches its run length,
// clears the counter and enables it for exactly that many cycles. It then
// reports the final count with a one-cycle done pulse.
//
// Optional feature macro: COUNTER_ABORT_EN
//   defined   - dropping req[winner] during RUN ends the run early (aborted=1)
//   undefined - req is ignored after LOAD and aborted is always 0
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   req      per-requester level request, held until granted
//   len      packed per-requester run lengths, slice i = len[i*WIDTH +: WIDTH]
//   gnt      one-hot grant, high from LOAD through DONE
//   busy     high in any state other than IDLE
//   cnt_ena  counter enable, high only in RUN
//   count    live counter value
//   done     one-cycle completion pulse
//   done_id  index of the requester that finished
//   result   final count of the last run, held until the next done
//   aborted  valid with done: run was cut short
module counter_run_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  cnt_ena,
    output logic [WIDTH-1:0]      count,
    output logic                  done,
    output logic [IDW-1:0]        done_id,
    output logic [WIDTH-1:0]      result,
    output logic                  aborted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_r;
    logic [IDW-1:0]   winner_r;
    logic [IDW-1:0]   last_id_r;
    logic [WIDTH-1:0] len_r;

    logic [IDW-1:0]   pick_s;
    logic             found_s;
    logic [WIDTH-1:0] len_sel_s;
    logic [WIDTH-1:0] count_inc_s;
    logic             abort_s;
    logic [NREQ-1:0]  pick_onehot_s;

    // Round-robin search: first pending requester after the last winner.
    always_comb begin
        pick_s  = '0;
        found_s = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last_id_r) + k) % NREQ;
            if (!found_s && req[idx]) begin
                pick_s  = IDW'(idx);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Datapath helpers: winner's length slice, counter increment, early-end request.
    always_comb begin
        len_sel_s     = len[winner_r*WIDTH +: WIDTH];
        count_inc_s   = count + {{(WIDTH-1){1'b0}}, 1'b1};
        pick_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
`ifdef COUNTER_ABORT_EN
        abort_s = ~req[winner_r];
`else
        abort_s = 1'b0;
`endif
    end

    // Scheduler FSM; every output is registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            winner_r  <= '0;
            last_id_r <= IDW'(NREQ - 1);
            len_r     <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            cnt_ena   <= 1'b0;
            count     <= '0;
            done      <= 1'b0;
            done_id   <= '0;
            result    <= '0;
            aborted   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (found_s) begin
                        winner_r <= pick_s;
                        gnt      <= pick_onehot_s;
                        busy     <= 1'b1;
                        state_r  <= LOAD;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                LOAD: begin
                    len_r     <= len_sel_s;
                    count     <= '0;
                    last_id_r <= winner_r;
                    if (len_sel_s == {WIDTH{1'b0}}) begin
                        // Zero-length run: report immediately with result 0.
                        done    <= 1'b1;
                        done_id <= winner_r;
                        result  <= '0;
                        aborted <= 1'b0;
                        state_r <= DONE;
                    end else begin
                        cnt_ena <= 1'b1;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    count <= count_inc_s;
                    // The run ends on the edge where count reaches len_r
                    // (or early on an abort); result is valid with done.
                    if (abort_s || (count_inc_s == len_r)) begin
                        cnt_ena <= 1'b0;
                        done    <= 1'b1;
                        done_id <= winner_r;
                        result  <= count_inc_s;
                        aborted <= abort_s && (count_inc_s != len_r);
                        state_r <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    gnt     <= '0;
                    busy    <= 1'b0;
                    cnt_ena <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_run_scheduler.sv
module tb_counter_run_scheduler;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  cnt_ena;
    logic [WIDTH-1:0]      count;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic [WIDTH-1:0]      result;
    logic                  aborted;

    counter_run_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .req(req), .len(len), .gnt(gnt),
        .busy(busy), .cnt_ena(cnt_ena), .count(count), .done(done),
        .done_id(done_id), .result(result), .aborted(aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int res;
        int ab;
        int lat;        // -1: not checked
        bit from_prev;  // latency measured from previous done instead of request
    } exp_t;

    exp_t sbq[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_done_cyc = 0;
    int ena_cnt = 0;
    int model_last = NREQ - 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals done.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            ena_cnt = 0;
        end else begin
            if (cnt_ena) ena_cnt++;
            if (done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done_id=%0d with nothing expected", done_id);
                end else begin
                    e = sbq.pop_front();
                    check("done_id", 32'(done_id), e.id);
                    check("result", 32'(result), e.res);
                    check("aborted", 32'(aborted), e.ab);
                    check("gnt", 32'(gnt), 32'(1) << e.id);
                    check("busy", 32'(busy), 32'd1);
                    check("ena_cycles", ena_cnt, e.res);
                    if (e.lat >= 0)
                        check("latency", e.from_prev ? cyc - last_done_cyc : cyc - start_cyc, e.lat);
                end
                last_done_cyc = cyc;
                ena_cnt = 0;
            end
        end
    end

    function automatic int lsel(input logic [NREQ*WIDTH-1:0] l, input int i);
        return int'(l[i*WIDTH +: WIDTH]);
    endfunction

    // Reference model: round-robin order from the last winner; each grant
    // yields one completion whose result is the programmed length.
    task automatic push_model(input logic [NREQ-1:0] mask, input int nruns, input bit remove);
        logic [NREQ-1:0] pend = mask;
        exp_t e;
        for (int r = 0; r < nruns; r++) begin
            for (int k = 1; k <= NREQ; k++) begin
                int i = (model_last + k) % NREQ;
                if (pend[i]) begin
                    e.id = i;
                    e.res = lsel(len, i);
                    e.ab = 0;
                    e.lat = (r == 0) ? e.res + 2 : e.res + 3;
                    e.from_prev = (r != 0);
                    sbq.push_back(e);
                    model_last = i;
                    if (remove) pend[i] = 1'b0;
                    break;
                end
            end
        end
    endtask

    // Drives a request set, then services done pulses until the scoreboard
    // drains. hold_runs>0 keeps all requests high for that many completions.
    task automatic run_batch(input logic [NREQ-1:0] mask, input int hold_runs);
        int t = 0;
        int seen = 0;
        @(negedge clk);
        push_model(mask, hold_runs > 0 ? hold_runs : $countones(mask), hold_runs == 0);
        start_cyc = cyc;
        req = mask;
        while (sbq.size() > 0 && t < 4000) begin
            @(negedge clk);
            t++;
            if (done) begin
                seen++;
                if (hold_runs > 0) begin
                    if (seen == hold_runs) req = '0;
                end else begin
                    req[done_id] = 1'b0;
                end
            end
        end
        if (t >= 4000) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d completions still pending", sbq.size());
            sbq.delete();
        end
        req = '0;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int t;
        exp_t e;
        reset = 1'b0;
        req = '0;
        len = '0;
        repeat (2) @(negedge clk);
        check("rst_outputs", {gnt, busy, cnt_ena, count, done, done_id, result, aborted}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Reset in the middle of a run: everything clears at once, no done.
        len[0 +: WIDTH] = 8'h40;
        req = 4'b0001;
        t = 0;
        while (count != 8'h23 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("reach_0x23", 32'(count), 32'h23);
        reset = 1'b0;
        req = '0;
        #1;
        check("midrun_rst", {gnt, busy, cnt_ena, count, done, done_id, result, aborted}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("no_done_in_rst", 32'(done), 32'd0);
        end
        reset = 1'b1;
        model_last = NREQ - 1;
        len[0 +: WIDTH] = 8'h05;
        run_batch(4'b0001, 0);

        // Single run, zero length, maximum length.
        len[2*WIDTH +: WIDTH] = 8'd10;
        run_batch(4'b0100, 0);
        len[1*WIDTH +: WIDTH] = 8'd0;
        run_batch(4'b0010, 0);
        len[3*WIDTH +: WIDTH] = 8'hFF;
        run_batch(4'b1000, 0);

        // Round-robin with all requests held for five runs.
        len = {4{8'd3}};
        model_last = 3;  // prior winner was requester 3
        run_batch(4'b1111, 5);

        // Requester 3 drops its request mid-run at count 7.
        @(negedge clk);
        len[3*WIDTH +: WIDTH] = 8'd50;
        e.id = 3;
        e.from_prev = 1'b0;
`ifdef COUNTER_ABORT_EN
        e.res = 8;
        e.ab = 1;
        e.lat = -1;
`else
        e.res = 50;
        e.ab = 0;
        e.lat = 52;
`endif
        sbq.push_back(e);
        model_last = 3;
        start_cyc = cyc;
        req = 4'b1000;
        t = 0;
        while (sbq.size() > 0 && t < 400) begin
            @(negedge clk);
            t++;
            if (count == 8'd7 && cnt_ena) req[3] = 1'b0;
            if (done) req = '0;
        end
        if (t >= 400) begin
            checks++;
            errors++;
            $display("FAIL abort_timeout: run never completed");
            sbq.delete();
        end
        req = '0;
        repeat (3) @(negedge clk);

        // Randomized request sets and lengths.
        for (int b = 0; b < 20; b++) begin
            logic [NREQ-1:0] m;
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++)
                len[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 30));
            run_batch(m, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
